// File: rtl/s38584_bitbank_wr.sv
// Write-side controller for the 16-entry single-bit state bank.
// Requests are accepted over valid/ready, held for ARM_CYCLES while g35 stays
// high, then committed into the bank in a single COMMIT cycle. Dropping g35
// while a request is pending discards it and pulses abort.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_IDLE   | ready for a request; bank_clr honoured here only
//  S_ARM    | request captured, counting the arming window
//  S_COMMIT | single cycle: write bank, bump counter, pulse done next cycle
module s38584_bitbank_wr #(
    parameter int ARM_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             g35,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [3:0]       wr_addr,
    input  logic             wr_data,
    input  logic             bank_clr,
    output logic [15:0]      bank_q,
    output logic             bank_par,
    output logic [CNT_W-1:0] commit_cnt,
    output logic             busy,
    output logic             done,
    output logic             abort
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    localparam logic [3:0] ARM_LAST = 4'(ARM_CYCLES - 1);

    state_e             state_q;
    logic [3:0]         arm_cnt_q;
    logic [3:0]         idx_q;
    logic               data_q;
    logic [15:0]        bank_mem_q;
    logic               par_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               abort_q;

    logic [15:0]        bank_wr_d;
    logic               par_wr_d;
    logic               accept;

    // Ready is a pure function of state and the blocking inputs; RN gates it
    // so nothing can be accepted while the block is held in reset.
    assign wr_ready = RN & (state_q == S_IDLE) & g35 & ~bank_clr;
    assign accept   = wr_valid & wr_ready;

    // Bank image and parity as they will look after the pending commit.
    always_comb begin
        bank_wr_d         = bank_mem_q;
        bank_wr_d[idx_q]  = data_q;
        par_wr_d          = ^bank_wr_d;
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q    <= S_IDLE;
            arm_cnt_q  <= 4'd0;
            idx_q      <= 4'd0;
            data_q     <= 1'b0;
            bank_mem_q <= 16'h0000;
            par_q      <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bank_clr && g35) begin
                        bank_mem_q <= 16'h0000;
                        par_q      <= 1'b0;
                    end else if (accept) begin
                        // Select bit 3 is inverted-polarity on the bank side.
                        idx_q     <= {~wr_addr[3], wr_addr[2:0]};
                        data_q    <= wr_data;
                        arm_cnt_q <= 4'd0;
                        state_q   <= S_ARM;
                        busy_q    <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (!g35) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + 4'd1;
                        if (arm_cnt_q == ARM_LAST) begin
                            state_q <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (g35) begin
                        bank_mem_q <= bank_wr_d;
                        par_q      <= par_wr_d;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        done_q <= 1'b1;
                    end else begin
                        abort_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bank_q     = bank_mem_q;
    assign bank_par   = par_q;
    assign commit_cnt = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign abort      = abort_q;

endmodule

// File: doc/s38584_bitbank_wr.md
Name: s38584_bitbank_wr

Overview:
- Write-side controller for the 16-entry single-bit state bank that the s38584 read cone samples through its 4-bit select decode.
- Accepts single-bit write requests over a valid/ready handshake and holds them through an arming window. Commits each bit into the bank only while the global enable g35 stays high.
- Exposes the bank contents, bank parity, a commit counter and status pulses to the read side.

Parameters:
- ARM_CYCLES, 4, cycles a request is held in ARM before commit; legal range 1..15.
- CNT_W, 8, width of the saturating commit counter.

Ports:
- CK  input  1  clock; all flops rising-edge.
- RN  input  1  asynchronous active-low reset.
- g35  input  1  global enable; low blocks acceptance and aborts an armed write.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  request accepted when wr_valid & wr_ready at a CK edge.
- wr_addr  input  4  bank index; bit 3 is the inverted-polarity select bit, so bank index = {~wr_addr[3], wr_addr[2:0]}.
- wr_data  input  1  bit to store.
- bank_clr  input  1  synchronous clear of the whole bank; honoured in IDLE only.
- bank_q  output  16  bank contents.
- bank_par  output  1  XOR of bank_q, registered.
- commit_cnt  output  CNT_W  number of commits, saturating.
- busy  output  1  high in ARM or COMMIT.
- done  output  1  one-cycle pulse, cycle after a commit.
- abort  output  1  one-cycle pulse when an armed request is dropped.

Behaviour:
- Reset (RN low, async):
  - state=IDLE; bank_q=0, bank_par=0, commit_cnt=0; busy=0, done=0, abort=0.
  - Capture registers cleared.
  - wr_ready is 0 while RN is low.
- States: IDLE, ARM, COMMIT.
- wr_ready = (state==IDLE) & g35 & ~bank_clr. It is combinational from state and inputs and does not depend on wr_valid.
- IDLE:
  - If bank_clr & g35: bank_q<=0 and bank_par<=0 next edge; no request is accepted that cycle.
  - Else on handshake: capture index and data, arm_cnt<=0, go to ARM.
  - bank_clr with g35 low is ignored.
- ARM:
  - arm_cnt increments each cycle.
  - When arm_cnt==ARM_CYCLES-1 and g35 is high, go to COMMIT.
  - If g35 is low at any edge in ARM: go to IDLE, pulse abort next cycle, leave the bank untouched.
  - bank_clr is ignored in ARM.
- COMMIT (exactly one cycle):
  - If g35 is high: bank_q[idx]<=data, bank_par updated in the same edge, commit_cnt+1 saturating at all-ones, done pulses the next cycle, go to IDLE.
  - If g35 is low in COMMIT: treat as abort, with no write.
- Latency: handshake at edge N gives a bank update at edge N+ARM_CYCLES+1; done is high during the cycle after that edge.
- The earliest next acceptance is the cycle done is high, because the state is already IDLE.
- Rewriting the same value still counts as a commit.
- bank_par always equals the XOR of bank_q after every edge.
- done and abort are never high together; each is high for exactly one cycle.
- Reset mid-ARM or mid-COMMIT: the pending write is lost and bank_q=0.

Test Plan:
- Reset, g35=1, ARM_CYCLES=4; request addr=4'b1010, data=1 at edge 0 → bank_q==16'h0004 after edge 5; done high the following cycle; commit_cnt=1; bank_par=1.
- Write addr=4'b0011 data=1, then addr=4'b1000 data=1 → bank_q==16'h0801, bank_par=0, commit_cnt=2. Then write addr=4'b0011 data=0 → bank_q==16'h0001, commit_cnt=3.
- Accept a request, drop g35 on the 2nd ARM cycle → abort pulses once, bank_q unchanged, commit_cnt unchanged, wr_ready back high when g35 returns.
- Assert bank_clr with wr_valid=1 in IDLE, bank=16'hFFFF → wr_ready=0 that cycle, bank_q=0 next, request accepted the following cycle. bank_clr held during ARM → no effect.
- Force 300 back-to-back commits with CNT_W=8 → commit_cnt sticks at 255; done still pulses per commit.
- Assert RN low during ARM, release → bank_q=0, no done, FSM IDLE, wr_ready follows g35.
